// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults and display state encoding for the FFT output stage
package fft_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int N_BINS_DEF = 8;
   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_SHOW = 1'b1;
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: synchronise a raw board switch, debounce it, flag debounced rising edges
module switch_debounce #(
   parameter int DEB_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic switch,
   output logic level,
   output logic rise_pulse
);
   localparam int CNT_W = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
   logic sync1_q, sync2_q, level_q, level_d, settle;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // count disagreeing cycles; accept the new level once it has held long enough
   always_comb begin
      settle = (sync2_q != level_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
      cnt_d = (sync2_q == level_q || settle) ? '0 : cnt_q + 1'b1;
      level_d = settle ? sync2_q : level_q;
   end
   // two-flop synchroniser plus debounce state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= switch;
         sync2_q <= sync1_q;
         cnt_q <= cnt_d;
         level_q <= level_d;
      end
   end
   // pulse is high in the cycle whose edge raises the level, so consumers step on that same edge
   assign rise_pulse = level_d & ~level_q;
   assign level = level_q;
endmodule

// File: rtl/fft_bin_display.sv
// fft_bin_display: capture one FFT frame and step the displayed bin on each switch press
module fft_bin_display
   import fft_pkg::*;
#(
   parameter int N_BINS = N_BINS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEB_CYCLES = 2,
   localparam int IDX_W = $clog2(N_BINS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              rearm,
   input  logic              switch,
   output logic [DATA_W-1:0] array,
   output logic [IDX_W-1:0]  bin_idx,
   output logic              frame_ok,
   output logic              err_len
);
   logic [0:0] state_q, state_d;
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d, bin_idx_q, bin_idx_d;
   logic [DATA_W-1:0] array_q, array_d;
   logic frame_ok_q, frame_ok_d, err_len_q, err_len_d;
   logic [DATA_W-1:0] mem_q [N_BINS];
   logic step, xfer, at_end, sw_level_unused;

   switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk),
      .reset(reset),
      .switch(switch),
      .level(sw_level_unused),
      .rise_pulse(step)
   );

   assign in_ready = state_q == ST_LOAD;
   assign xfer = in_valid && in_ready;
   assign at_end = wr_ptr_q == IDX_W'(N_BINS - 1);

   // LOAD collects words and checks frame length; SHOW refreshes the display and steps the index
   always_comb begin
      state_d = state_q;
      wr_ptr_d = wr_ptr_q;
      bin_idx_d = bin_idx_q;
      array_d = array_q;
      frame_ok_d = frame_ok_q;
      err_len_d = err_len_q;
      if (state_q == ST_LOAD) begin
         if (xfer) begin
            wr_ptr_d = (at_end || in_last) ? '0 : wr_ptr_q + 1'b1;
            err_len_d = err_len_q | (at_end != in_last);
            if (at_end && in_last) begin
               state_d = ST_SHOW;
               bin_idx_d = '0;
               frame_ok_d = 1'b1;
            end
         end
      end else if (rearm) begin
         state_d = ST_LOAD;
         frame_ok_d = 1'b0;
      end else begin
         array_d = mem_q[bin_idx_q];
         bin_idx_d = bin_idx_q + IDX_W'(step);
      end
   end

   // control and display registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_LOAD;
         wr_ptr_q <= '0;
         bin_idx_q <= '0;
         array_q <= '0;
         frame_ok_q <= 1'b0;
         err_len_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         bin_idx_q <= bin_idx_d;
         array_q <= array_d;
         frame_ok_q <= frame_ok_d;
         err_len_q <= err_len_d;
      end
   end

   // frame buffer; contents are don't-care after reset so it carries none
   always_ff @(posedge clk) begin
      if (xfer) mem_q[wr_ptr_q] <= in_data;
   end

   assign array = array_q;
   assign bin_idx = bin_idx_q;
   assign frame_ok = frame_ok_q;
   assign err_len = err_len_q;
endmodule

// File: tb/tb_fft_bin_display.sv
// tb_fft_bin_display: scoreboard bench for frame capture, stepping, errors and reset
module tb_fft_bin_display;
   localparam int N = 8;
   typedef struct {
      logic [2:0]  idx;
      logic [15:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic rearm = 1'b0;
   logic switch = 1'b0;
   logic [15:0] in_data = '0;
   logic in_ready, frame_ok, err_len;
   logic [15:0] array;
   logic [2:0] bin_idx;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ref_idx = 0;
   exp_t exp_q[$];
   logic [15:0] ref_buf [N];
   logic pend = 1'b0;
   logic [15:0] pend_data = '0;
   logic [2:0] last_idx = '0;
   logic last_fok = 1'b0;

   fft_bin_display dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .rearm(rearm),
      .switch(switch),
      .array(array),
      .bin_idx(bin_idx),
      .frame_ok(frame_ok),
      .err_len(err_len)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard monitor: each index change while a frame is shown pops one expected step
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      cyc++;
      if (pend) begin
         check("step_array", {16'h0, array}, {16'h0, pend_data});
         pend = 1'b0;
      end
      if (reset && last_fok && frame_ok && bin_idx != last_idx) begin
         if (exp_q.size() == 0) check("unexpected_step", {29'h0, bin_idx}, {29'h0, last_idx});
         else begin
            e = exp_q.pop_front();
            check("step_idx", {29'h0, bin_idx}, {29'h0, e.idx});
            check("step_cycle", cyc, e.due);
            pend = 1'b1;
            pend_data = e.data;
         end
      end
      last_idx = bin_idx;
      last_fok = frame_ok;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // called at a negedge; the switch is first sampled on the next edge
   task automatic press(input int hi, input int lo, input bit expect_step);
      switch = 1'b1;
      if (expect_step) begin
         ref_idx = (ref_idx + 1) % N;
         exp_q.push_back('{idx: 3'(ref_idx), data: ref_buf[ref_idx], due: cyc + 4});
      end
      repeat (hi) @(negedge clk);
      switch = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic load_frame(input logic [15:0] base, input logic [15:0] stp, input int n,
                             input int last_at, input bit full);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data = base + 16'(i) * stp;
         in_last = (i == last_at);
         check("beat_ready", {31'h0, in_ready}, 32'h1);
         if (full) ref_buf[i] = in_data;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      if (full) begin
         ref_idx = 0;
         check("load_in_ready", {31'h0, in_ready}, 32'h0);
         check("load_frame_ok", {31'h0, frame_ok}, 32'h1);
         check("load_bin_idx", {29'h0, bin_idx}, 32'h0);
         @(negedge clk);
         check("load_array", {16'h0, array}, {16'h0, ref_buf[0]});
      end
   endtask

   initial begin
      #1 reset = 1'b0;
      idle(2);
      check("rst_array", {16'h0, array}, 32'h0);
      check("rst_bin_idx", {29'h0, bin_idx}, 32'h0);
      check("rst_frame_ok", {31'h0, frame_ok}, 32'h0);
      check("rst_err_len", {31'h0, err_len}, 32'h0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      reset = 1'b1;
      idle(1);
      load_frame(16'h0011, 16'h0011, 8, 7, 1'b1);
      for (int i = 0; i < 9; i++) press(3, 3, 1'b1);
      idle(4);
      check("wrap_idx", {29'h0, bin_idx}, 32'h1);
      press(1, 8, 1'b0);
      check("glitch_idx", {29'h0, bin_idx}, 32'h1);
      press(50, 8, 1'b1);
      check("hold_idx", {29'h0, bin_idx}, 32'h2);
      check("sb_empty_show", exp_q.size(), 0);
      // rearm lands in the same cycle as the step pulse
      switch = 1'b1;
      idle(3);
      rearm = 1'b1;
      @(negedge clk);
      rearm = 1'b0;
      check("rearm_idx", {29'h0, bin_idx}, 32'h2);
      check("rearm_frame_ok", {31'h0, frame_ok}, 32'h0);
      check("rearm_in_ready", {31'h0, in_ready}, 32'h1);
      switch = 1'b0;
      idle(6);
      load_frame(16'h0500, 16'h0001, 5, 4, 1'b0);
      check("short_err_len", {31'h0, err_len}, 32'h1);
      check("short_in_ready", {31'h0, in_ready}, 32'h1);
      check("short_frame_ok", {31'h0, frame_ok}, 32'h0);
      load_frame(16'h0700, 16'h0001, 8, -1, 1'b0);
      check("long_in_ready", {31'h0, in_ready}, 32'h1);
      check("long_frame_ok", {31'h0, frame_ok}, 32'h0);
      load_frame(16'h1000, 16'h0001, 8, 7, 1'b1);
      check("recover_err_len", {31'h0, err_len}, 32'h1);
      // reset in the middle of the 4th beat of a new frame
      rearm = 1'b1;
      @(negedge clk);
      rearm = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = 16'h0900 + 16'(i);
         @(negedge clk);
      end
      in_data = 16'h0903;
      #2 reset = 1'b0;
      #1;
      check("mid_rst_array", {16'h0, array}, 32'h0);
      check("mid_rst_bin_idx", {29'h0, bin_idx}, 32'h0);
      check("mid_rst_frame_ok", {31'h0, frame_ok}, 32'h0);
      check("mid_rst_err_len", {31'h0, err_len}, 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      idle(1);
      check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
      load_frame(16'h2000, 16'h0001, 8, 7, 1'b1);
      press(3, 3, 1'b1);
      idle(10);
      check("sb_empty_end", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
